// File: rtl/rtcstopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// rtcstopwatch_ctrl
//
// Bus-facing controller for the BCD stopwatch core. It turns register writes
// into single-cycle start/stop/clear strobes, captures lap (split) times from
// the running stopwatch value into a small FIFO, and returns status, lap data
// and the live stopwatch value on reads.
//
// Ports:
//   i_clk, i_reset      system clock, synchronous active-high reset
//   i_wb_stb/we/addr    one-cycle bus request, write enable, register select
//                       (0 CTRL/STATUS, 1 LAP, 2 VALUE, 3 reserved)
//   i_wb_data           write data
//   o_wb_ack/o_wb_data  acknowledge and read data, one cycle after i_wb_stb
//   i_lap               hardware lap request pulse (already synchronised)
//   i_sw_value          current stopwatch BCD value
//   i_sw_running        stopwatch running flag
//   o_sw_clear/start/stop  registered one-cycle strobes to the stopwatch
// ---------------------------------------------------------------------------
module rtcstopwatch_ctrl #(
    parameter int LGLAPS = 3
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [1:0]  i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_data,
    input  logic        i_lap,
    input  logic [30:0] i_sw_value,
    input  logic        i_sw_running,
    output logic        o_sw_clear,
    output logic        o_sw_start,
    output logic        o_sw_stop
);

    localparam int DEPTH = 1 << LGLAPS;

    localparam logic [LGLAPS:0]   CNT_ONE  = (LGLAPS+1)'(1);
    localparam logic [LGLAPS:0]   CNT_FULL = (LGLAPS+1)'(DEPTH);
    localparam logic [LGLAPS-1:0] PTR_ONE  = LGLAPS'(1);

    localparam logic [1:0] ADDR_CTRL  = 2'd0;
    localparam logic [1:0] ADDR_LAP   = 2'd1;
    localparam logic [1:0] ADDR_VALUE = 2'd2;

    logic              ack_q,   ack_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              clear_q, clear_d;
    logic              start_q, start_d;
    logic              stop_q,  stop_d;
    logic [LGLAPS-1:0] wr_ptr_q, wr_ptr_d;
    logic [LGLAPS-1:0] rd_ptr_q, rd_ptr_d;
    logic [LGLAPS:0]   count_q,  count_d;
    logic              ovf_q,    ovf_d;

    logic [30:0]       lap_mem_q [DEPTH];

    logic              ctrl_wr;
    logic              lap_rd;
    logic              fifo_empty;
    logic              fifo_full;
    logic              flush;
    logic              lap_req;
    logic              pop;
    logic              push;
    logic [31:0]       status_word;

    // Bits above the flush flag carry no meaning; folded here so they are
    // visibly consumed.
    logic              unused_wdata;
    assign unused_wdata = ^i_wb_data[31:4];

    // Request decode and FIFO bookkeeping. A flush wins over any lap request
    // in the same cycle; a full FIFO still accepts a push if a pop frees the
    // head in that same cycle, otherwise the entry is lost and overflow sticks.
    always_comb begin
        ctrl_wr    = i_wb_stb && i_wb_we && (i_wb_addr == ADDR_CTRL);
        lap_rd     = i_wb_stb && !i_wb_we && (i_wb_addr == ADDR_LAP);
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CNT_FULL);
        flush      = ctrl_wr && i_wb_data[3];
        lap_req    = i_lap || (ctrl_wr && i_wb_data[2]);
        pop        = lap_rd && !fifo_empty;
        push       = lap_req && !flush && (!fifo_full || pop);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_d = count_q - CNT_ONE;
            end
            if (lap_req && fifo_full && !pop) begin
                ovf_d = 1'b1;
            end
        end
    end

    // Stopwatch strobes. Code 3 only clears when the watch is stopped so a
    // restart of a running watch does not lose its accumulated time.
    always_comb begin
        clear_d = 1'b0;
        start_d = 1'b0;
        stop_d  = 1'b0;
        if (ctrl_wr) begin
            case (i_wb_data[1:0])
                2'b00: stop_d = 1'b1;
                2'b01: start_d = 1'b1;
                2'b10: begin
                    stop_d  = 1'b1;
                    clear_d = 1'b1;
                end
                default: begin
                    start_d = 1'b1;
                    clear_d = !i_sw_running;
                end
            endcase
        end
    end

    // Read data mux; writes and reserved reads return zero.
    always_comb begin
        status_word                = '0;
        status_word[0]             = i_sw_running;
        status_word[1]             = ovf_q;
        status_word[8+LGLAPS:8]    = count_q;

        ack_d   = i_wb_stb;
        rdata_d = '0;
        if (i_wb_stb && !i_wb_we) begin
            case (i_wb_addr)
                ADDR_CTRL:  rdata_d = status_word;
                ADDR_LAP:   rdata_d = fifo_empty ? 32'h0 : {1'b1, lap_mem_q[rd_ptr_q]};
                ADDR_VALUE: rdata_d = {1'b0, i_sw_value};
                default:    rdata_d = '0;
            endcase
        end
    end

    // Control and status registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            clear_q  <= 1'b0;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            clear_q  <= clear_d;
            start_q  <= start_d;
            stop_q   <= stop_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Lap storage has no reset: the pointers and count decide what is valid.
    always_ff @(posedge i_clk) begin
        if (!i_reset && push) begin
            lap_mem_q[wr_ptr_q] <= i_sw_value;
        end
    end

    assign o_wb_ack   = ack_q;
    assign o_wb_data  = rdata_q;
    assign o_sw_clear = clear_q;
    assign o_sw_start = start_q;
    assign o_sw_stop  = stop_q;

endmodule

// File: doc/rtcstopwatch_ctrl.md
Name: rtcstopwatch_ctrl

Overview:
Bus-facing controller for the BCD stopwatch core. It decodes register writes into single-cycle start/stop/clear strobes with the team's stop/clear semantics. It captures lap (split) times from the stopwatch value into a small FIFO, and returns status and lap data on reads. It sits between the Wishbone slave port of the RTC peripheral and the stopwatch datapath.

Parameters:
LGLAPS, 3, log2 of lap FIFO depth (depth = 2**LGLAPS = 8 entries)

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_wb_stb  in  1  bus request strobe, one cycle per transaction
i_wb_we  in  1  1 = write, 0 = read
i_wb_addr  in  2  register select: 0 CTRL/STATUS, 1 LAP, 2 VALUE, 3 reserved
i_wb_data  in  32  write data
o_wb_ack  out  1  acknowledge, exactly one cycle after each i_wb_stb
o_wb_data  out  32  read data, valid with o_wb_ack
i_lap  in  1  hardware lap request, single-cycle pulse (already synchronised)
i_sw_value  in  31  current stopwatch BCD value
i_sw_running  in  1  stopwatch running flag
o_sw_clear  out  1  clear strobe to stopwatch
o_sw_start  out  1  start strobe to stopwatch
o_sw_stop  out  1  stop strobe to stopwatch

Behaviour:
- Reset: o_wb_ack=0, o_wb_data=0, o_sw_clear/start/stop=0, lap FIFO empty (count 0), overflow flag 0. A stb in the same cycle as reset is dropped and gets no ack.
- All outputs are registered. Ack and strobe latency is 1 cycle after the stb. Every stb (read, write, any address) is acked.
- CTRL write (addr 0), decoded from data[1:0] using i_sw_running sampled in the stb cycle:
  - 00: stop.
  - 01: start.
  - 10: stop + clear in the same cycle.
  - 11: if stopped, clear + start in the same cycle; if running, start only (no clear).
- Additional CTRL write bits:
  - data[2]=1 requests a lap capture.
  - data[3]=1 flushes the lap FIFO and clears the overflow flag. The flush takes priority over a same-write lap request.
  - Strobes are 1-cycle pulses and are never mutually asserted except the combinations listed above.
- Lap capture: a bus lap request (data[2]) or i_lap pushes i_sw_value from the request cycle. Both requests in the same cycle push one entry only.
- FIFO boundary rules:
  - Push when full with no pop: entry dropped, overflow flag set. Overflow is sticky until flush or reset.
  - Push and pop in the same cycle: both performed, count unchanged. This is legal even when full.
  - Pop when empty: no state change.
- LAP read (addr 1): returns {valid, entry[30:0]} and pops the head. valid=1 if the FIFO was non-empty; otherwise the word is 0.
- VALUE read (addr 2): {1'b0, i_sw_value} sampled in the stb cycle.
- STATUS read (addr 0):
  - bit0 = i_sw_running, bit1 = overflow.
  - bits[8+LGLAPS:8] = count, 0..2**LGLAPS.
  - All other bits 0.
- Reserved address: writes are ignored; reads return 0.
- Writes to addr 1 and addr 2 are ignored (acked).
- Pointer arithmetic: LGLAPS-bit read/write pointers wrap modulo depth; count is LGLAPS+1 bits.
- Reset mid-operation: pending strobes and ack are cancelled the next cycle, and FIFO contents are discarded.

Test Plan:
- Stopped, write CTRL=1 -> o_sw_start=1 exactly one cycle after stb, o_wb_ack in the same cycle, start/stop/clear 0 the following cycle.
- i_sw_running=1, write CTRL=3 -> start=1, clear=0. i_sw_running=0, write CTRL=3 -> start=1 and clear=1 in the same cycle. Write CTRL=2 while running -> stop=1 and clear=1.
- i_sw_value=31'h01_02_35_47, pulse i_lap, then read LAP -> 32'h8102_3547. A second LAP read -> 32'h0000_0000. STATUS count reads 1 then 0.
- Push 9 laps (values 1..9) -> STATUS bit1=1, count=8. LAP reads return 1..8 with valid. Write CTRL=8 -> overflow=0, count=0.
- FIFO full: a LAP read coincident with i_lap -> read returns the oldest entry, count stays 8, overflow stays 0.
- Assert i_reset the cycle after a CTRL=1 write with 3 laps stored -> ack and start deasserted, STATUS read after reset returns count 0, overflow 0.
